// File: rtl/regfile_writeback.sv
// Write-side initiator for the integer register file.
// Arbitrates completed ALU and load results onto the single register-file
// write port through a one-cycle registered output stage, guarantees the ALU
// a win after STARVE_MAX consecutive losses, and keeps the per-register
// pending scoreboard used by the issue stage for RAW hazard stalls.
module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [AW-1:0]     lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic [2**AW-1:0]  busy,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [XLEN-1:0]   wr_data
);

  localparam int NREGS = 2**AW;
  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  logic [1:0]       starve_cnt;
  logic             alu_starved;
  logic             alu_xfer_p0;
  logic             lsu_xfer_p0;
  logic             vld_p0;
  logic [AW-1:0]    rd_p0;
  logic [XLEN-1:0]  data_p0;

  logic             vld_p1;
  logic [AW-1:0]    addr_p1;
  logic [XLEN-1:0]  data_p1;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  // Stage p0: arbitration. Readies depend only on lsu_valid and the
  // registered starve count, never on alu_valid, so the two transfers are
  // mutually exclusive by construction.
  assign alu_starved = (starve_cnt == STARVE_LIM);
  assign lsu_ready   = !alu_starved;
  assign alu_ready   = alu_starved | !lsu_valid;
  assign alu_xfer_p0 = alu_valid & alu_ready;
  assign lsu_xfer_p0 = lsu_valid & lsu_ready;
  assign vld_p0      = alu_xfer_p0 | lsu_xfer_p0;
  assign rd_p0       = alu_xfer_p0 ? alu_rd   : lsu_rd;
  assign data_p0     = alu_xfer_p0 ? alu_data : lsu_data;

  // Count consecutive ALU losses; any ALU win or idle ALU restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 2'd0;
    end else if (!alu_valid || alu_xfer_p0) begin
      starve_cnt <= 2'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 2'd1;
    end
  end

  // Stage p0 -> p1: register the winning result; x0 results are swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0 && (rd_p0 != '0);
      if (vld_p0) begin
        addr_p1 <= rd_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign wr_en   = vld_p1;
  assign wr_addr = addr_p1;
  assign wr_data = data_p1;

  // Scoreboard next state: clear on transfer, then set on issue so a new
  // issuer of the same register keeps ownership; x0 is never pending.
  always_comb begin
    busy_nxt = busy_q;
    if (vld_p0) begin
      busy_nxt[rd_p0] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy = busy_q;

endmodule
